vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Controller for the single-port 8-bit RGB332 frame buffer feeding the VGA 640x480 output path. Prefetches pixels in raster order into a small FIFO so the VGA timing logic gets one pixel per pixel-clock enable. Shares the remaining RAM slots with one writer port, using display priority and a starvation guard. Sits between the frame-buffer RAM and the top-level `PIXEL_DATA` input. Runs in the `FCLK` domain; `PIX_CE` marks pixel slots.

## Interface
- `ADDR_W`, default 19: RAM address width.
- `FRAME_PIXELS`, default 307200: pixels per frame (640*480).
- `FIFO_DEPTH`, default 8: prefetch FIFO entries, power of two.
- `STARVE_LIMIT`, default 8: writer wait cycles before it pre-empts display fetch.

Ports:
- `FCLK` in 1: single clock.
- `RST_IN` in 1: reset, asynchronous assert, active-low.
- `PIX_CE` in 1: pixel-slot enable, at most one per cycle.
- `DISPLAY_EN` in 1: visible-area flag from the timing generator.
- `FRAME_START` in 1: one-cycle pulse, issued before the first visible pixel of each frame.
- `PIXEL_DATA` out 8: registered pixel to the VGA output.
- `UNDERFLOW` out 1: sticky flag, set when a pop finds the FIFO empty.
- `WR_REQ` in 1: writer request; `WR_ADDR`/`WR_DATA` must stay stable until ack.
- `WR_ADDR` in `ADDR_W`: write address.
- `WR_DATA` in 8: write pixel.
- `WR_ACK` out 1: one-cycle pulse; the write is accepted.
- `MEM_ADDR` out `ADDR_W`: RAM address, registered.
- `MEM_RE` out 1: RAM read strobe, registered.
- `MEM_WE` out 1: RAM write strobe, registered.
- `MEM_WDATA` out 8: RAM write data, registered.
- `MEM_RDATA` in 8: RAM read data, valid exactly 1 cycle after `MEM_RE`.

## Operation
- Reset values: `PIXEL_DATA`=0, `UNDERFLOW`=0, `WR_ACK`=0, `MEM_RE`=0, `MEM_WE`=0, `MEM_ADDR`=0, `MEM_WDATA`=0. Internal state after reset:
  - FIFO empty.
  - Fetch address = 0.
  - Fetch halted until the first `FRAME_START`.
  - All counters 0.
- Reserved count = FIFO occupancy + reads issued but not yet pushed. It never exceeds `FIFO_DEPTH`.
- Display fetch is eligible when all of these hold:
  - fetch is not halted;
  - fetch address < `FRAME_PIXELS`;
  - reserved < `FIFO_DEPTH`.
- Writer is eligible when `WR_REQ`=1 and `WR_ACK` is not asserted this cycle. This blocks a double grant on a held request.
- Arbitration each cycle, exactly one grant or none:
  1. writer, if eligible and wait counter ≥ `STARVE_LIMIT`;
  2. else display, if eligible;
  3. else writer, if eligible.
- Display grant:
  - next cycle `MEM_RE`=1 and `MEM_ADDR`=fetch address;
  - fetch address increments;
  - at `FRAME_PIXELS` the fetch halts; it does not wrap.
- Writer grant:
  - next cycle `WR_ACK`=1, `MEM_WE`=1, `MEM_ADDR`=`WR_ADDR`, `MEM_WDATA`=`WR_DATA`;
  - if `WR_ADDR` ≥ `FRAME_PIXELS`, `WR_ACK` still pulses but `MEM_WE` stays 0.
- Wait counter:
  - increments each cycle the writer is eligible but not granted, saturating;
  - clears on writer grant;
  - clears when `WR_REQ`=0.
- Pop occurs when `PIX_CE`=1 and `DISPLAY_EN`=1.
  - FIFO non-empty: `PIXEL_DATA` <= FIFO head.
  - FIFO empty: `PIXEL_DATA` <= 0 and `UNDERFLOW` <= 1.
  - `UNDERFLOW` clears only on reset.
- `PIXEL_DATA` holds its value between pops.
- Returned read data is pushed the cycle `MEM_RDATA` is valid. Push and pop in the same cycle are both allowed.
- `FRAME_START`:
  - flushes the FIFO;
  - fetch address <= 0, and fetch is enabled;
  - reads still in flight are discarded on return via a discard counter and are never pushed;
  - takes priority over a simultaneous pop (no pop, `PIXEL_DATA` holds) and over a simultaneous push (data dropped);
  - no display grant in the `FRAME_START` cycle; a writer grant is allowed.
- `RST_IN` low mid-transaction aborts everything; the writer must re-request.

## Timing
- Grant decided in cycle N → `MEM_*` valid in N+1 → `MEM_RDATA` in N+2 → pushed at end of N+2 → poppable in N+3.
- Pop in cycle P → `PIXEL_DATA` valid from P+1.
- Writer, with no display demand: `WR_REQ` rising in cycle N → `WR_ACK`/`MEM_WE` in N+1.
- Worst-case writer latency: `STARVE_LIMIT`+1 cycles.
- After `FRAME_START`, the FIFO is full `FIFO_DEPTH`+2 cycles later when there is no writer traffic.

## Test plan
- Reset: hold `RST_IN`=0 → all outputs 0. Release with no `FRAME_START` → `MEM_RE` never asserts.
- Prefetch fill: RAM[a]=a[7:0]; pulse `FRAME_START` with no pops → exactly 8 `MEM_RE` at addresses 0..7, then idle. Then pop every other cycle → `PIXEL_DATA` = 0x00, 0x01, 0x02, … with no `UNDERFLOW`.
- Blanking write: `DISPLAY_EN`=0, FIFO full, `WR_REQ` with addr 0x12345, data 0xA5 → one `WR_ACK`, `MEM_WE`=1, `MEM_ADDR`=0x12345, `MEM_WDATA`=0xA5 on the next cycle. Holding `WR_REQ` one more cycle → no second ack.
- Starvation: `PIX_CE`=1 every cycle during active video with `WR_REQ` held → `WR_ACK` within 9 cycles. Pixel stream stays in order.
- Underflow and range: pop on an empty FIFO → `PIXEL_DATA`=0x00, `UNDERFLOW`=1 and it stays 1. A write to address 307200 → `WR_ACK` pulses, `MEM_WE` stays 0.
- Mid-flight flush: pulse `FRAME_START` one cycle after a read issue → the stale return is not pushed. The next pop yields RAM[0].

Source files
------------

// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if: display, writer and frame-buffer RAM signals of the VRAM arbiter
// slave modport: the arbiter; master modport: timing generator, writer and RAM side
interface vga_vram_arbiter_if #(parameter int ADDR_W = 19);
  logic pix_ce;
  logic display_en;
  logic frame_start;
  logic [7:0] pixel_data;
  logic underflow;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_re;
  logic mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  modport master (
    output pix_ce, display_en, frame_start, wr_req, wr_addr, wr_data, mem_rdata,
    input pixel_data, underflow, wr_ack, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    input pix_ce, display_en, frame_start, wr_req, wr_addr, wr_data, mem_rdata,
    output pixel_data, underflow, wr_ack, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: raster-order pixel prefetch FIFO sharing a single-port frame buffer with one writer
// clk, rst_n (async, active-low); bus: pix_ce/display_en/frame_start in, pixel_data/underflow out,
// wr_req/wr_addr/wr_data in, wr_ack out, mem_addr/mem_re/mem_we/mem_wdata out, mem_rdata in
module vga_vram_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input logic clk,
  input logic rst_n,
  vga_vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0] FRAME_END = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [PW+1:0] DEPTH = (PW+2)'(FIFO_DEPTH);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);
  logic [7:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic [ADDR_W-1:0] fetch_addr;
  logic halted, rd_valid;
  logic [1:0] discard_cnt;
  logic [WW-1:0] wait_cnt;
  logic [PW+1:0] reserved;
  logic disp_ok, wr_ok, grant_wr, grant_disp, pop, pop_hit, push, wr_in_range;
  // Reads already marked for discard hold no FIFO slot, so they are not counted as reserved.
  always_comb begin
    reserved    = (PW+2)'(count) + (PW+2)'(bus.mem_re) + (PW+2)'(rd_valid) - (PW+2)'(discard_cnt);
    disp_ok     = !halted && !bus.frame_start && ({1'b0, fetch_addr} < FRAME_END) && (reserved < DEPTH);
    wr_ok       = bus.wr_req && !bus.wr_ack;
    grant_wr    = wr_ok && (wait_cnt >= LIMIT || !disp_ok);
    grant_disp  = disp_ok && !grant_wr;
    pop         = bus.pix_ce && bus.display_en && !bus.frame_start;
    pop_hit     = pop && count != '0;
    push        = rd_valid && discard_cnt == '0 && !bus.frame_start;
    wr_in_range = {1'b0, bus.wr_addr} < FRAME_END;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= bus.mem_rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.pixel_data <= '0;
      bus.underflow  <= 1'b0;
      bus.wr_ack     <= 1'b0;
      bus.mem_re     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      fetch_addr     <= '0;
      halted         <= 1'b1;
      rd_valid       <= 1'b0;
      discard_cnt    <= '0;
      wait_cnt       <= '0;
    end else begin
      bus.mem_re <= grant_disp;
      bus.mem_we <= grant_wr && wr_in_range;
      bus.wr_ack <= grant_wr;
      bus.mem_addr <= grant_disp ? fetch_addr : grant_wr ? bus.wr_addr : bus.mem_addr;
      bus.mem_wdata <= grant_wr ? bus.wr_data : bus.mem_wdata;
      rd_valid <= bus.mem_re;
      wait_cnt <= (!bus.wr_req || grant_wr) ? '0 : (wr_ok && wait_cnt < LIMIT) ? wait_cnt + 1'b1 : wait_cnt;
      if (bus.frame_start) begin
        fetch_addr  <= '0;
        halted      <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        discard_cnt <= {1'b0, bus.mem_re};
      end else begin
        if (grant_disp) fetch_addr <= fetch_addr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop_hit) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop_hit);
        if (rd_valid && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
        if (pop) bus.pixel_data <= pop_hit ? fifo[rd_ptr] : 8'h00;
        if (pop && !pop_hit) bus.underflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed table and sequence checks for the VRAM arbiter
module tb_vga_vram_arbiter;
  localparam int AW = 19;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vga_vram_arbiter_if #(.ADDR_W(AW)) bus ();
  vga_vram_arbiter #(.ADDR_W(AW), .FRAME_PIXELS(307200), .FIFO_DEPTH(8), .STARVE_LIMIT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  // RAM model: RAM[a] = a[7:0], data valid the cycle after mem_re
  always @(posedge clk)
    if (bus.mem_re) bus.mem_rdata <= bus.mem_addr[7:0];
  logic [AW-1:0] re_q [$];
  always @(negedge clk)
    if (bus.mem_re) re_q.push_back(bus.mem_addr);
  typedef struct {
    logic pix, den, req;
    logic [AW-1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_pix;
    logic exp_uf, exp_ack, exp_we, chk_mem;
    logic [AW-1:0] exp_addr;
    logic [7:0] exp_wdata;
  } vec_t;
  vec_t vecs [$];
  int checks = 0;
  int failures = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic add(input logic pix, den, req, input logic [AW-1:0] a, input logic [7:0] d,
                     input logic [7:0] ep, input logic euf, eack, ewe, chk,
                     input logic [AW-1:0] ea, input logic [7:0] ew);
    vec_t v;
    v.pix = pix; v.den = den; v.req = req; v.addr = a; v.data = d;
    v.exp_pix = ep; v.exp_uf = euf; v.exp_ack = eack; v.exp_we = ewe;
    v.chk_mem = chk; v.exp_addr = ea; v.exp_wdata = ew;
    vecs.push_back(v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] exp_pix;
    int lat, acks, seen;
    for (int i = 0; i < 32; i++) add(i % 2 == 0, 1'b1, 1'b0, '0, 8'h00, 8'(i / 2), 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    for (int i = 0; i < 12; i++) add(1'b0, 1'b0, 1'b0, '0, 8'h00, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 19'h12345, 8'hA5, 8'd15, 1'b0, 1'b1, 1'b1, 1'b1, 19'h12345, 8'hA5);
    add(1'b0, 1'b0, 1'b1, 19'h12345, 8'hA5, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 19'h12345, 8'hA5, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 19'd307200, 8'h3C, 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 19'd307200, 8'h3C, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    bus.pix_ce = 1'b0; bus.display_en = 1'b0; bus.frame_start = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset pixel_data", bus.pixel_data, 0);
    check("reset underflow", bus.underflow, 0);
    check("reset wr_ack", bus.wr_ack, 0);
    check("reset mem_re", bus.mem_re, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no fetch before frame_start", re_q.size(), 0);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (20) @(negedge clk);
    check("fill read count", re_q.size(), 8);
    for (int i = 0; i < re_q.size() && i < 8; i++) check($sformatf("fill addr %0d", i), re_q[i], i);
    re_q.delete();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.pix_ce = vecs[i].pix; bus.display_en = vecs[i].den; bus.wr_req = vecs[i].req;
      bus.wr_addr = vecs[i].addr; bus.wr_data = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d pixel_data", i), bus.pixel_data, vecs[i].exp_pix);
      check($sformatf("vec%0d underflow", i), bus.underflow, vecs[i].exp_uf);
      check($sformatf("vec%0d wr_ack", i), bus.wr_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d mem_we", i), bus.mem_we, vecs[i].exp_we);
      if (vecs[i].chk_mem) begin
        check($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
        check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
      end
    end
    // starvation: pop every cycle, then hold a write request
    bus.display_en = 1'b1; bus.pix_ce = 1'b1;
    exp_pix = 8'd16;
    repeat (4) begin
      @(negedge clk);
      check("stream pixel", bus.pixel_data, exp_pix);
      exp_pix++;
    end
    bus.wr_req = 1'b1; bus.wr_addr = 19'h00100; bus.wr_data = 8'h5A;
    lat = 0; acks = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      check("starve stream pixel", bus.pixel_data, exp_pix);
      exp_pix++;
      if (bus.wr_ack) begin
        acks++;
        if (lat == 0) lat = c;
        check("starve mem_we", bus.mem_we, 1);
        check("starve mem_addr", bus.mem_addr, 19'h00100);
        bus.wr_req = 1'b0;
      end
    end
    check("starve ack count", acks, 1);
    check("starve latency within 9", (lat >= 1 && lat <= 9), 1);
    bus.pix_ce = 1'b0; bus.display_en = 1'b0;
    check("no underflow in stream", bus.underflow, 0);
    // underflow: pop right after a flush
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0; bus.display_en = 1'b1; bus.pix_ce = 1'b1;
    @(negedge clk);
    bus.pix_ce = 1'b0; bus.display_en = 1'b0;
    check("empty pop pixel", bus.pixel_data, 0);
    check("empty pop underflow", bus.underflow, 1);
    repeat (15) @(negedge clk);
    check("underflow sticky", bus.underflow, 1);
    // mid-flight flush: frame_start with a read in flight (d=0) or returning (d=1)
    for (int d = 0; d < 2; d++) begin
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      repeat (15) @(negedge clk);
      bus.display_en = 1'b1; bus.pix_ce = 1'b1;
      @(negedge clk);
      bus.pix_ce = 1'b0;
      check($sformatf("flush%0d head before", d), bus.pixel_data, 0);
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
        if (bus.mem_re) seen = 1;
        else @(negedge clk);
      end
      check($sformatf("flush%0d read issued", d), seen, 1);
      if (d == 1) @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      repeat (15) @(negedge clk);
      bus.pix_ce = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("flush%0d pop %0d", d, k), bus.pixel_data, k);
      end
      bus.pix_ce = 1'b0; bus.display_en = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
